// File: rtl/adder4_seq_ctrl.sv
// Sequencer for a WIDTH-bit add (a+b+cin) built from repeated passes through one
// external combinational 4-bit adder slice, least significant nibble first.
module adder4_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             carry;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;
  logic [WIDTH-1:0] sum_merged;
  logic             last;
  logic             accept;

  assign last   = (idx == IDXW'(NIBBLES - 1));
  assign accept = in_valid & in_ready;

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = (state != IDLE);
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;
    sum_merged = sum_reg;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) state_nxt = RUN;
      end
      RUN: begin
        add_a   = a_reg[4*idx +: 4];
        add_b   = b_reg[4*idx +: 4];
        add_cin = carry;
        // Full result including the nibble being produced this pass
        sum_merged[4*idx +: 4] = add_sum;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && accept) begin
        a_reg <= a;
        b_reg <= b;
        carry <= cin;
        idx   <= '0;
      end else if (state == RUN) begin
        sum_reg <= sum_merged;
        carry   <= add_cout;
        if (last) begin
          idx    <= '0;
          sum_q  <= sum_merged;
          cout_q <= add_cout;
          ovf_q  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                    (sum_merged[WIDTH-1] != a_reg[WIDTH-1]);
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_adder4_seq_ctrl.sv
// Directed self-checking bench for adder4_seq_ctrl (WIDTH=16) with a behavioural
// 4-bit adder slice attached to the sequencer's adder port.
module tb_adder4_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] a, b;
  logic        cin;
  logic        out_valid, out_ready;
  logic [15:0] sum;
  logic        cout, ovf, busy;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  adder4_seq_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Accept one request and walk the passes, checking the slice drive each cycle.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic ci);
    logic [4:0] t;
    logic       c;
    a = av; b = bv; cin = ci;
    in_valid = 1'b1;
    chk("accept_in_ready", in_ready, 1);
    step;
    in_valid = 1'b0;
    a = 16'h1111; b = 16'h1111; cin = 1'b0;  // post-accept changes must not matter
    c = ci;
    for (int k = 0; k < 4; k++) begin
      chk("run_add_a", add_a, av[4*k +: 4]);
      chk("run_add_b", add_b, bv[4*k +: 4]);
      chk("run_add_cin", add_cin, c);
      chk("run_out_valid", out_valid, 0);
      chk("run_in_ready", in_ready, 0);
      t = {1'b0, av[4*k +: 4]} + {1'b0, bv[4*k +: 4]} + {4'b0, c};
      c = t[4];
      step;
    end
  endtask

  task automatic check_done(input logic [15:0] es, input logic ec, input logic eo);
    chk("done_out_valid", out_valid, 1);
    chk("done_sum", sum, es);
    chk("done_cout", cout, ec);
    chk("done_ovf", ovf, eo);
    chk("done_busy", busy, 1);
    chk("done_in_ready", in_ready, 0);
  endtask

  task automatic release_op(input logic [15:0] es);
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    chk("idle_out_valid", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_sum_held", sum, es);
  endtask

  initial begin
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic        vc [3];
    logic [15:0] vs [3];
    logic        vco [3];
    logic        vov [3];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_add_a", add_a, 0);
    step; step;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    start_op(16'h0000, 16'hFFFF, 1'b1);
    check_done(16'h0000, 1'b1, 1'b0);
    release_op(16'h0000);

    start_op(16'h7FFF, 16'h0001, 1'b0);
    check_done(16'h8000, 1'b0, 1'b1);
    release_op(16'h8000);

    start_op(16'hFFFF, 16'hFFFF, 1'b1);
    check_done(16'hFFFF, 1'b1, 1'b0);
    release_op(16'hFFFF);

    // Backpressure: result held, new request ignored
    start_op(16'h0001, 16'h0002, 1'b0);
    in_valid = 1'b1; a = 16'h1111; b = 16'h1111;
    for (int k = 0; k < 5; k++) begin
      check_done(16'h0003, 1'b0, 1'b0);
      step;
    end
    in_valid = 1'b0;
    release_op(16'h0003);
    step;
    chk("bp_no_accept_busy", busy, 0);

    // Reset during the third RUN pass
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    step; step;
    chk("mid_run_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    step;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("after_rst_no_valid", out_valid, 0);
      step;
    end
    start_op(16'h1234, 16'h4321, 1'b0);
    check_done(16'h5555, 1'b0, 1'b0);
    release_op(16'h5555);

    // Back-to-back with in_valid and out_ready held high: one op per 6 cycles
    va = '{16'h0001, 16'hABCD, 16'h8000};
    vb = '{16'h0001, 16'h1111, 16'h8000};
    vc = '{1'b0, 1'b1, 1'b0};
    vs = '{16'h0002, 16'hBCDF, 16'h0000};
    vco = '{1'b0, 1'b0, 1'b1};
    vov = '{1'b0, 1'b0, 1'b1};
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = va[k]; b = vb[k]; cin = vc[k];
      chk("b2b_in_ready", in_ready, 1);
      step;
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
      for (int j = 0; j < 3; j++) begin
        chk("b2b_run_no_valid", out_valid, 0);
        step;
      end
      chk("b2b_run_last_in_ready", in_ready, 0);
      step;
      chk("b2b_out_valid", out_valid, 1);
      chk("b2b_sum", sum, vs[k]);
      chk("b2b_cout", cout, vco[k]);
      chk("b2b_ovf", ovf, vov[k]);
      step;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_end_in_ready", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
